turn_scheduler: RTL and testbench

Sequences the per-player movement steps of the two-player game: a programmable move tick triggers one round in which player 1 and then player 2 are each granted exactly one single-cycle move slot on the map-control block. It samples that block's collision flags, declares the winner, and stops the game. The tick period speeds up as rounds accumulate. It sits between the game-mode FSM and the map-control block, and drives that block's `selected_player` input.

---
 rtl/game_pkg.sv | 34 +++
 rtl/tick_divider.sv | 26 ++
 rtl/turn_scheduler.sv | 143 ++++++++++++++
 tb/tb_turn_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: mode, per-turn FSM state, winner encoding, map-control selector codes.
// Pure declarations; no logic, no latency.
package game_pkg;

    typedef enum logic [1:0] {
        MENU  = 2'd0,
        START = 2'd1,
        PLAY  = 2'd2,
        PAUSE = 2'd3
    } game_mode;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10,
        DRAW = 2'b11
    } winner_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        MOVE1     = 3'd2,
        SETTLE1   = 3'd3,
        MOVE2     = 3'd4,
        SETTLE2   = 3'd5,
        RESOLVE   = 3'd6,
        OVER      = 3'd7
    } turn_state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_P1   = 2'b01;
    localparam logic [1:0] SEL_P2   = 2'b11;

endpackage

// File: rtl/tick_divider.sv
// Loadable 32-bit down-counter that flags zero; load wins over enable, holds at 0.
// zero is combinational from the count register; no backpressure.
module tick_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        en,
    output logic        zero
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 32'd0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != 32'd0)) begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    assign zero = (r_cnt == 32'd0);

endmodule

// File: rtl/turn_scheduler.sv
// Per-tick round sequencer: one-cycle grant to P1 then P2, samples collisions, declares winner.
// Grant decoded from the state register; a round spans 5 cycles, ticks are period+5 apart.
module turn_scheduler
    import game_pkg::*;
#(
    parameter int unsigned TICK_CYCLES_INIT = 2_000_000,
    parameter int unsigned TICK_CYCLES_MIN  = 500_000,
    parameter int unsigned SPEEDUP_STEP     = 100_000,
    parameter int unsigned SPEEDUP_ROUNDS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  game_mode    mode,
    input  logic        player1_collision,
    input  logic        player2_collision,
    output logic [1:0]  selected_player,
    output logic        game_over,
    output winner_t     winner,
    output logic [15:0] round_count
);

    localparam logic [32:0] C_DEC_FLOOR = 33'(TICK_CYCLES_MIN) + 33'(SPEEDUP_STEP);

    turn_state_t r_state, w_state_nxt;
    logic [31:0] r_period;
    logic [15:0] r_round_count;
    logic        r_p1_hit, r_p2_hit, r_game_over;
    winner_t     r_winner;

    logic        w_load, w_en, w_zero, w_clear, w_round_ok, w_hit;
    logic [15:0] w_rc_inc;
    logic        w_rc_sat, w_speedup;
    logic [31:0] w_period_dec, w_reload_val;

    assign w_rc_sat     = (r_round_count == 16'hFFFF);
    assign w_rc_inc     = w_rc_sat ? r_round_count : r_round_count + 16'd1;
    assign w_speedup    = !w_rc_sat && ((32'(w_rc_inc) % SPEEDUP_ROUNDS) == 32'd0);
    // Compare at 33 bits so period < STEP clamps instead of wrapping.
    assign w_period_dec = ({1'b0, r_period} >= C_DEC_FLOOR) ? r_period - 32'(SPEEDUP_STEP)
                                                            : 32'(TICK_CYCLES_MIN);
    assign w_reload_val = r_period - 32'd1;

    tick_divider u_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_reload_val),
        .en       (w_en),
        .zero     (w_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_en        = 1'b0;
        w_clear     = 1'b0;
        w_round_ok  = 1'b0;
        w_hit       = 1'b0;
        if (mode == START) begin
            w_state_nxt = IDLE;
            w_clear     = 1'b1;
        end else if (r_state == OVER) begin
            w_state_nxt = OVER;
        end else if (mode != PLAY) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = WAIT_TICK;
                    w_load      = 1'b1;
                end
                WAIT_TICK: begin
                    if (w_zero) begin
                        w_state_nxt = MOVE1;
                        w_load      = 1'b1;
                    end else begin
                        w_en = 1'b1;
                    end
                end
                MOVE1:   w_state_nxt = SETTLE1;
                SETTLE1: w_state_nxt = MOVE2;
                MOVE2:   w_state_nxt = SETTLE2;
                SETTLE2: w_state_nxt = RESOLVE;
                RESOLVE: begin
                    if (!r_p1_hit && !r_p2_hit) begin
                        w_state_nxt = WAIT_TICK;
                        w_round_ok  = 1'b1;
                    end else begin
                        w_state_nxt = OVER;
                        w_hit       = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_period      <= TICK_CYCLES_INIT;
            r_round_count <= 16'd0;
            r_p1_hit      <= 1'b0;
            r_p2_hit      <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= NONE;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_period      <= TICK_CYCLES_INIT;
                r_round_count <= 16'd0;
                r_p1_hit      <= 1'b0;
                r_p2_hit      <= 1'b0;
                r_game_over   <= 1'b0;
                r_winner      <= NONE;
            end else begin
                if (r_state == SETTLE1) r_p1_hit <= player1_collision;
                if (r_state == SETTLE2) r_p2_hit <= player2_collision;
                if (w_round_ok) begin
                    r_round_count <= w_rc_inc;
                    if (w_speedup) r_period <= w_period_dec;
                end
                if (w_hit) begin
                    r_game_over <= 1'b1;
                    r_winner    <= (r_p1_hit && r_p2_hit) ? DRAW : (r_p1_hit ? P2 : P1);
                end
            end
        end
    end

    always_comb begin
        case (r_state)
            MOVE1:   selected_player = SEL_P1;
            MOVE2:   selected_player = SEL_P2;
            default: selected_player = SEL_NONE;
        endcase
    end

    assign game_over   = r_game_over;
    assign winner      = r_winner;
    assign round_count = r_round_count;

endmodule

// File: tb/tb_turn_scheduler.sv
// Randomized self-checking bench for turn_scheduler against a round-timeline model.
module tb_turn_scheduler;
    import game_pkg::*;

    logic        clk;
    logic        rst;
    game_mode    mode_a, mode_b;
    logic        p1c, p2c;
    logic [1:0]  sel_a, sel_b;
    logic        go_a, go_b;
    winner_t     win_a, win_b;
    logic [15:0] rc_a, rc_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit use_b    = 1'b0;
    int move_q[$];

    logic [1:0]  obs_sel;
    logic        obs_go;
    winner_t     obs_win;
    logic [15:0] obs_rc;
    turn_state_t obs_state;

    turn_scheduler #(
        .TICK_CYCLES_INIT(8), .TICK_CYCLES_MIN(4), .SPEEDUP_STEP(1), .SPEEDUP_ROUNDS(32)
    ) u_a (
        .clk(clk), .rst(rst), .mode(mode_a),
        .player1_collision(p1c), .player2_collision(p2c),
        .selected_player(sel_a), .game_over(go_a), .winner(win_a), .round_count(rc_a)
    );

    turn_scheduler #(
        .TICK_CYCLES_INIT(20), .TICK_CYCLES_MIN(10), .SPEEDUP_STEP(6), .SPEEDUP_ROUNDS(2)
    ) u_b (
        .clk(clk), .rst(rst), .mode(mode_b),
        .player1_collision(p1c), .player2_collision(p2c),
        .selected_player(sel_b), .game_over(go_b), .winner(win_b), .round_count(rc_b)
    );

    assign obs_sel   = use_b ? sel_b : sel_a;
    assign obs_go    = use_b ? go_b  : go_a;
    assign obs_win   = use_b ? win_b : win_a;
    assign obs_rc    = use_b ? rc_b  : rc_a;
    assign obs_state = use_b ? u_b.r_state : u_a.r_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget 20000", cyc);
            $fatal(1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_mode(input game_mode m);
        if (use_b) mode_b = m; else mode_a = m;
    endtask

    // Model of a game: grants land at predicted cycles, collisions only matter in settle cycles.
    task automatic run_game(input int nrounds, input int h1, input int h2,
                            output int bad_sel, output int bad_rc);
        int per, per_used, rc, t_move, min_p, step_p, rnds;
        logic [1:0] exp_sel;
        per    = use_b ? 20 : 8;
        min_p  = use_b ? 10 : 4;
        step_p = use_b ? 6 : 1;
        rnds   = use_b ? 2 : 32;
        rc = 0; bad_sel = 0; bad_rc = 0;
        move_q.delete();
        set_mode(PLAY);
        t_move = cyc + 1 + per;
        for (int r = 1; r <= nrounds; r++) begin
            per_used = per;
            while (cyc < t_move + 4) begin
                step();
                exp_sel = (cyc == t_move) ? 2'b01 : ((cyc == t_move + 2) ? 2'b11 : 2'b00);
                if (obs_sel == 2'b01) move_q.push_back(cyc);
                if (obs_sel !== exp_sel) bad_sel++;
                if (obs_rc !== 16'(rc)) bad_rc++;
                p1c = 1'($urandom_range(0, 1));
                p2c = 1'($urandom_range(0, 1));
                if (cyc == t_move + 1) p1c = (r == h1);
                if (cyc == t_move + 3) p2c = (r == h2);
            end
            if ((r == h1) || (r == h2)) break;
            if (rc < 65535) begin
                rc++;
                if (rc % rnds == 0) per = (per - step_p < min_p) ? min_p : per - step_p;
            end
            t_move = t_move + per_used + 5;
        end
    endtask

    task automatic restart();
        mode_a = START; mode_b = START;
        p1c = 1'b0; p2c = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_a = START; mode_b = START; p1c = 1'b0; p2c = 1'b0;
        step(); step(); step();
        checks++; if (sel_a !== 2'b00) begin failures++; $display("FAIL reset_sel_a: got %b want 00", sel_a); end
        checks++; if (go_a !== 1'b0) begin failures++; $display("FAIL reset_go_a: got %b want 0", go_a); end
        checks++; if (win_a !== NONE) begin failures++; $display("FAIL reset_win_a: got %0d want 0", win_a); end
        checks++; if (rc_a !== 16'd0) begin failures++; $display("FAIL reset_rc_a: got %0d want 0", rc_a); end
        checks++; if (sel_b !== 2'b00 || go_b !== 1'b0 || rc_b !== 16'd0) begin
            failures++; $display("FAIL reset_b: got sel=%b go=%b rc=%0d want 00/0/0", sel_b, go_b, rc_b); end
        checks++; if (u_a.r_state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want IDLE", u_a.r_state); end
        checks++; if (u_b.r_period !== 32'd20) begin failures++; $display("FAIL reset_period: got %0d want 20", u_b.r_period); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int n, bs, br, bad_gap;
        use_b = 1'b0; restart();
        n = 3 + $urandom_range(0, 2);
        run_game(n, 0, 0, bs, br);
        checks++; if (bs !== 0) begin failures++; $display("FAIL basic_grant_seq: got %0d bad cycles want 0", bs); end
        checks++; if (br !== 0) begin failures++; $display("FAIL basic_round_count: got %0d bad cycles want 0", br); end
        checks++; if (move_q.size() !== n) begin failures++; $display("FAIL basic_grants: got %0d want %0d", move_q.size(), n); end
        bad_gap = 0;
        for (int i = 1; i < move_q.size(); i++) if (move_q[i] - move_q[i-1] != 13) bad_gap++;
        checks++; if (bad_gap !== 0) begin failures++; $display("FAIL basic_spacing: got %0d gaps not 13 want 0", bad_gap); end
        step();
        checks++; if (rc_a !== 16'(n)) begin failures++; $display("FAIL basic_rc_final: got %0d want %0d", rc_a, n); end
        checks++; if (go_a !== 1'b0) begin failures++; $display("FAIL basic_go: got %b want 0", go_a); end
    endtask

    task automatic test_collide(input bit hit1, input bit hit2, input winner_t exp_win);
        int n, bs, br, bad_hold;
        use_b = 1'b0; restart();
        n = $urandom_range(1, 3);
        run_game(n, hit1 ? n : 0, hit2 ? n : 0, bs, br);
        checks++; if (bs !== 0) begin failures++; $display("FAIL collide_grant_seq: got %0d bad cycles want 0", bs); end
        step();
        checks++; if (go_a !== 1'b1) begin failures++; $display("FAIL collide_go: got %b want 1", go_a); end
        checks++; if (win_a !== exp_win) begin failures++; $display("FAIL collide_winner: got %0d want %0d", win_a, exp_win); end
        checks++; if (rc_a !== 16'(n - 1)) begin failures++; $display("FAIL collide_rc: got %0d want %0d", rc_a, n - 1); end
        mode_a = ($urandom_range(0, 1) == 0) ? PAUSE : PLAY;
        bad_hold = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (sel_a !== 2'b00 || go_a !== 1'b1 || win_a !== exp_win) bad_hold++;
        end
        checks++; if (bad_hold !== 0) begin failures++; $display("FAIL over_hold: got %0d bad cycles want 0", bad_hold); end
        if (exp_win == DRAW) begin
            mode_a = START;
            step();
            checks++; if (go_a !== 1'b0 || win_a !== NONE || rc_a !== 16'd0) begin
                failures++; $display("FAIL start_clear: got go=%b win=%0d rc=%0d want 0/0/0", go_a, win_a, rc_a); end
        end
    endtask

    task automatic test_speedup();
        int bs, br, bad_gap;
        int exp_gap[6] = '{25, 25, 19, 19, 15, 15};
        use_b = 1'b1; restart();
        run_game(7, 0, 0, bs, br);
        checks++; if (bs !== 0) begin failures++; $display("FAIL speed_grant_seq: got %0d bad cycles want 0", bs); end
        checks++; if (move_q.size() !== 7) begin failures++; $display("FAIL speed_grants: got %0d want 7", move_q.size()); end
        bad_gap = 0;
        for (int i = 1; i < move_q.size() && i <= 6; i++)
            if (move_q[i] - move_q[i-1] != exp_gap[i-1]) bad_gap++;
        checks++; if (bad_gap !== 0) begin failures++; $display("FAIL speed_spacing: got %0d wrong gaps want 0", bad_gap); end
        step();
        checks++; if (rc_b !== 16'd7) begin failures++; $display("FAIL speed_rc: got %0d want 7", rc_b); end
        checks++; if (u_b.r_period !== 32'd10) begin failures++; $display("FAIL speed_clamp: got %0d want 10", u_b.r_period); end
        mode_b = START; step();
        use_b = 1'b0;
    endtask

    task automatic wait_sel(input logic [1:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (obs_sel === want) ok = 1'b1;
        end
    endtask

    task automatic test_abort_rst();
        int bs, br, bad;
        bit ok;
        use_b = 1'b0; restart();
        run_game(2, 0, 0, bs, br);
        p1c = 1'b0; p2c = 1'b0;
        wait_sel(2'b01, ok);
        checks++; if (!ok) begin failures++; $display("FAIL abort_wait: got no 01 grant want one within 100 cycles"); end
        step();
        rst = 1'b1;
        step();
        checks++; if (u_a.r_state !== IDLE) begin failures++; $display("FAIL abort_state: got %0d want IDLE", u_a.r_state); end
        checks++; if (sel_a !== 2'b00 || go_a !== 1'b0 || win_a !== NONE || rc_a !== 16'd0) begin
            failures++; $display("FAIL abort_outputs: got sel=%b go=%b win=%0d rc=%0d want 00/0/0/0", sel_a, go_a, win_a, rc_a); end
        rst = 1'b0; mode_a = START;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sel_a !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL abort_no_grant: got %0d grant cycles want 0", bad); end
    endtask

    task automatic test_mode_drop();
        int bs, br, bad;
        bit ok;
        use_b = 1'b0; restart();
        run_game(2, 0, 0, bs, br);
        p1c = 1'b0; p2c = 1'b0;
        wait_sel(2'b11, ok);
        checks++; if (!ok) begin failures++; $display("FAIL drop_wait: got no 11 grant want one within 100 cycles"); end
        mode_a = ($urandom_range(0, 1) == 0) ? PAUSE : MENU;
        step();
        checks++; if (u_a.r_state !== IDLE) begin failures++; $display("FAIL drop_state: got %0d want IDLE", u_a.r_state); end
        checks++; if (rc_a !== 16'd2) begin failures++; $display("FAIL drop_rc: got %0d want 2", rc_a); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sel_a !== 2'b00 || rc_a !== 16'd2) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL drop_hold: got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        rst = 1'b1; mode_a = START; mode_b = START; p1c = 1'b0; p2c = 1'b0;
        test_reset();
        test_basic();
        test_collide(1'b1, 1'b0, P2);
        test_collide(1'b0, 1'b1, P1);
        test_collide(1'b1, 1'b1, DRAW);
        test_speedup();
        test_abort_rst();
        test_mode_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
